// File: rtl/init_hold_switch_mc_if.sv
// rtl/init_hold_switch_mc_if.sv - step/value bus of the initial-value hold/release switch
interface init_hold_switch_mc_if #(
  parameter int DATA_W = 36,
  parameter int N_CH   = 4,
  parameter int TIME_W = 32
);
  logic                     step_valid;
  logic [TIME_W-1:0]        sim_time;
  logic [N_CH*DATA_W-1:0]   start_val;
  logic [N_CH*DATA_W-1:0]   calc_val;
  logic                     restart;
  logic [N_CH*DATA_W-1:0]   out_val;
  logic                     out_valid;
  logic [N_CH-1:0]          released;
  logic [1:0]               state;

  modport master (
    output step_valid, sim_time, start_val, calc_val, restart,
    input  out_val, out_valid, released, state
  );

  modport slave (
    input  step_valid, sim_time, start_val, calc_val, restart,
    output out_val, out_valid, released, state
  );
endinterface

// File: rtl/init_hold_switch_mc.sv
// rtl/init_hold_switch_mc.sv - multi-channel start-value hold with staggered release onto computed values
// Optional per-channel force_hold input enabled by macro INIT_HOLD_FORCE_EN.
module init_hold_switch_mc #(
  parameter int DATA_W    = 36,
  parameter int N_CH      = 4,
  parameter int TIME_W    = 32,
  parameter int T_HOLD    = 10000,
  parameter int T_STAGGER = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef INIT_HOLD_FORCE_EN
  input  logic [N_CH-1:0]     force_hold,
`endif
  init_hold_switch_mc_if.slave bus
);

  localparam int W           = N_CH * DATA_W;
  localparam int CNT_W       = (T_STAGGER < 1) ? 1 : $clog2(T_STAGGER + 1);
  localparam int STAG_M1     = (T_STAGGER > 0) ? T_STAGGER - 1 : 0;
  localparam bit ALL_AT_ONCE = (T_STAGGER == 0) || (N_CH == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d, eval_state;
  logic [N_CH-1:0]   rel_q, rel_d, next_rel, hold_mask;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] last_q;
  logic [W-1:0]      out_q, out_d;
  logic              out_valid_q;
  logic              rearm;

  // Released bits form a thermometer code; the next channel is the lowest clear bit.
  always_comb begin
    next_rel    = rel_q;
    next_rel[0] = 1'b1;
    for (int i = 1; i < N_CH; i++) begin
      next_rel[i] = rel_q[i] | rel_q[i-1];
    end
  end

  assign rearm = bus.restart || (bus.step_valid && (bus.sim_time < last_q));

  always_comb begin
    state_d    = state_q;
    rel_d      = rel_q;
    cnt_d      = cnt_q;
    eval_state = (state_q == IDLE) ? HOLD : state_q;
    if (rearm) begin
      state_d = HOLD;
      rel_d   = '0;
      cnt_d   = '0;
    end else if (bus.step_valid) begin
      state_d = eval_state;
      case (eval_state)
        HOLD: begin
          if (bus.sim_time > TIME_W'(T_HOLD)) begin
            cnt_d = '0;
            if (ALL_AT_ONCE) begin
              rel_d   = '1;
              state_d = RUN;
            end else begin
              rel_d   = N_CH'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAG_M1)) begin
            cnt_d = '0;
            rel_d = next_rel;
            if (next_rel[N_CH-1]) begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          rel_d = '1;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // Selection uses the released bits after this step's update.
  always_comb begin
`ifdef INIT_HOLD_FORCE_EN
    hold_mask = ~rel_d | force_hold;
`else
    hold_mask = ~rel_d;
`endif
    out_d = out_q;
    if (bus.step_valid) begin
      for (int i = 0; i < N_CH; i++) begin
        out_d[i*DATA_W +: DATA_W] = hold_mask[i] ? bus.start_val[i*DATA_W +: DATA_W]
                                                 : bus.calc_val[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rel_q       <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rel_q       <= rel_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= bus.step_valid;
      if (bus.step_valid) begin
        last_q <= bus.sim_time;
      end
    end
  end

  assign bus.out_val   = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.released  = rel_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_init_hold_switch_mc.sv
// tb/tb_init_hold_switch_mc.sv - scoreboard bench for init_hold_switch_mc, staggered and all-at-once builds
module tb_init_hold_switch_mc;
  localparam int DW = 36;
  localparam int N  = 4;
  localparam int TW = 32;
  localparam int TH = 10000;
  localparam int W  = N * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] force_hold = '0;

  init_hold_switch_mc_if #(.DATA_W(DW), .N_CH(N), .TIME_W(TW)) ia ();
  init_hold_switch_mc_if #(.DATA_W(DW), .N_CH(N), .TIME_W(TW)) ib ();

  init_hold_switch_mc #(.DATA_W(DW), .N_CH(N), .TIME_W(TW), .T_HOLD(TH), .T_STAGGER(16)) dut_a (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INIT_HOLD_FORCE_EN
    .force_hold(force_hold),
`endif
    .bus(ia)
  );

  init_hold_switch_mc #(.DATA_W(DW), .N_CH(N), .TIME_W(TW), .T_HOLD(TH), .T_STAGGER(0)) dut_b (
    .clk(clk),
    .rst_n(rst_n),
`ifdef INIT_HOLD_FORCE_EN
    .force_hold(force_hold),
`endif
    .bus(ib)
  );

  typedef struct packed {
    logic [W-1:0] val;
    logic [N-1:0] rel;
    logic [1:0]   st;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]    m_st[2];
  logic [N-1:0]  m_rel[2];
  int            m_cnt[2];
  logic [TW-1:0] m_last[2];
  int            stag[2] = '{16, 0};
  logic [W-1:0]  sv, cv;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 2'd0; m_rel[k] = '0; m_cnt[k] = 0; m_last[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input logic [TW-1:0] t, input logic rs, output exp_t e);
    if (rs || t < m_last[k]) begin
      m_rel[k] = '0; m_cnt[k] = 0; m_st[k] = 2'd1;
    end else begin
      if (m_st[k] == 2'd0) m_st[k] = 2'd1;
      case (m_st[k])
        2'd1: if (t > TH) begin
          m_cnt[k] = 0;
          if (stag[k] == 0) begin m_rel[k] = '1; m_st[k] = 2'd3; end
          else begin m_rel[k] = 4'b0001; m_st[k] = 2'd2; end
        end
        2'd2: begin
          m_cnt[k]++;
          if (m_cnt[k] == stag[k]) begin
            m_cnt[k] = 0;
            m_rel[k] = {m_rel[k][N-2:0], 1'b1};
            if (m_rel[k][N-1]) m_st[k] = 2'd3;
          end
        end
        default: m_rel[k] = '1;
      endcase
    end
    m_last[k] = t;
    for (int i = 0; i < N; i++)
      e.val[i*DW +: DW] = (m_rel[k][i] && !force_hold[i]) ? cv[i*DW +: DW] : sv[i*DW +: DW];
    e.rel = m_rel[k];
    e.st  = m_st[k];
  endtask

  task automatic rand_vals();
    logic [DW-1:0] tmp;
    for (int i = 0; i < N; i++) begin
      tmp = {4'($urandom), 32'($urandom)};
      sv[i*DW +: DW] = tmp;
      tmp = {4'($urandom), 32'($urandom)};
      cv[i*DW +: DW] = tmp;
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("out_valid_a_pulse", W'(ia.out_valid), W'(1));
    chk("out_valid_b_pulse", W'(ib.out_valid), W'(1));
    if (qa.size() == 0 || qb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", qa.size());
    end else begin
      e = qa.pop_front();
      chk("out_val_a", ia.out_val, e.val);
      chk("released_a", W'(ia.released), W'(e.rel));
      chk("state_a", W'(ia.state), W'(e.st));
      e = qb.pop_front();
      chk("out_val_b", ib.out_val, e.val);
      chk("released_b", W'(ib.released), W'(e.rel));
      chk("state_b", W'(ib.state), W'(e.st));
    end
  endtask

  // Called at a negedge; leaves at the negedge after the pulse has dropped.
  task automatic do_step(input logic [TW-1:0] t, input logic rs);
    exp_t e;
    ia.sim_time = t;  ib.sim_time = t;
    ia.start_val = sv; ib.start_val = sv;
    ia.calc_val = cv;  ib.calc_val = cv;
    ia.restart = rs;   ib.restart = rs;
    ia.step_valid = 1'b1; ib.step_valid = 1'b1;
    model_step(0, t, rs, e); qa.push_back(e);
    model_step(1, t, rs, e); qb.push_back(e);
    @(negedge clk);
    ia.step_valid = 1'b0; ib.step_valid = 1'b0;
    ia.restart = 1'b0;    ib.restart = 1'b0;
    pop_check();
    @(negedge clk);
    chk("out_valid_a_drop", W'(ia.out_valid), W'(0));
    chk("out_valid_b_drop", W'(ib.out_valid), W'(0));
  endtask

  initial begin
    ia.step_valid = 1'b0; ia.sim_time = '0; ia.start_val = '0; ia.calc_val = '0; ia.restart = 1'b0;
    ib.step_valid = 1'b0; ib.sim_time = '0; ib.start_val = '0; ib.calc_val = '0; ib.restart = 1'b0;
    model_reset();
    sv = {N{36'h111}};
    cv = {N{36'h222}};

    // Reset state
    @(negedge clk);
    chk("rst_out_val", ia.out_val, '0);
    chk("rst_state", W'(ia.state), W'(0));
    chk("rst_released", W'(ia.released), W'(0));
    chk("rst_out_valid", W'(ia.out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hold window including the boundary sim_time == T_HOLD
    for (int t = 0; t <= TH; t++) begin
      do_step(TW'(t), 1'b0);
      if (t == 0 || t == TH) begin
        chk("hold_out", ia.out_val, {N{36'h111}});
        chk("hold_state", W'(ia.state), W'(1));
        chk("hold_rel", W'(ia.released), W'(0));
      end
    end

    // Staggered release vs all-at-once
    for (int k = 0; k <= 48; k++) begin
      do_step(TW'(TH + 1 + k), 1'b0);
      if (k == 0) begin
        chk("rel0_a", W'(ia.released), W'(4'b0001));
        chk("rel0_out_a", ia.out_val, {36'h111, 36'h111, 36'h111, 36'h222});
        chk("rel0_state_a", W'(ia.state), W'(2));
        chk("all_rel_b", W'(ib.released), W'(4'b1111));
        chk("all_state_b", W'(ib.state), W'(3));
        chk("all_out_b", ib.out_val, {N{36'h222}});
      end
      if (k == 15) chk("rel15_a", W'(ia.released), W'(4'b0001));
      if (k == 16) chk("rel16_a", W'(ia.released), W'(4'b0011));
      if (k == 32) chk("rel32_a", W'(ia.released), W'(4'b0111));
      if (k == 47) chk("rel47_state_a", W'(ia.state), W'(2));
      if (k == 48) begin
        chk("rel48_a", W'(ia.released), W'(4'b1111));
        chk("run_state_a", W'(ia.state), W'(3));
      end
    end

    // Time rollback re-arms
    rand_vals();
    do_step(TW'(20000), 1'b0);
    rand_vals();
    do_step(TW'(5), 1'b0);
    chk("rollback_rel_a", W'(ia.released), W'(0));
    chk("rollback_state_a", W'(ia.state), W'(1));
    chk("rollback_out_a", ia.out_val, sv);
    chk("rollback_out_b", ib.out_val, sv);

    // Restart beats the release of channel 2
    for (int k = 0; k < 32; k++) begin
      rand_vals();
      do_step(TW'(TH + 1 + k), 1'b0);
    end
    chk("pre_restart_rel_a", W'(ia.released), W'(4'b0011));
    rand_vals();
    do_step(TW'(TH + 33), 1'b1);
    chk("restart_rel_a", W'(ia.released), W'(0));
    chk("restart_state_a", W'(ia.state), W'(1));
    chk("restart_out_a", ia.out_val, sv);
    rand_vals();
    do_step(TW'(TH + 34), 1'b0);
    chk("rearmed_rel_a", W'(ia.released), W'(4'b0001));

    // Asynchronous reset mid-release
    for (int k = 0; k < 5; k++) begin
      rand_vals();
      do_step(TW'(TH + 40 + k), 1'b0);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_a", ia.out_val, '0);
    chk("async_rel_a", W'(ia.released), W'(0));
    chk("async_state_a", W'(ia.state), W'(0));
    chk("async_out_b", ib.out_val, '0);
    chk("async_state_b", W'(ib.state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rand_vals();
    do_step(TW'(TH + 200), 1'b0);
    chk("post_rst_rel_a", W'(ia.released), W'(4'b0001));
    chk("post_rst_state_a", W'(ia.state), W'(2));

    // Restart on a cycle without a step
    ia.restart = 1'b1; ib.restart = 1'b1;
    @(negedge clk);
    ia.restart = 1'b0; ib.restart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 2'd1; m_rel[k] = '0; m_cnt[k] = 0;
    end
    chk("idle_restart_state_a", W'(ia.state), W'(1));
    chk("idle_restart_rel_a", W'(ia.released), W'(0));
    chk("idle_restart_rel_b", W'(ib.released), W'(0));
    chk("idle_restart_valid_a", W'(ia.out_valid), W'(0));
    rand_vals();
    do_step(TW'(TH + 300), 1'b0);

`ifdef INIT_HOLD_FORCE_EN
    for (int k = 1; k <= 48; k++) begin
      rand_vals();
      do_step(TW'(TH + 300 + k), 1'b0);
    end
    force_hold = 4'b0100;
    rand_vals();
    do_step(TW'(TH + 400), 1'b0);
    chk("force_ch2_a", W'(ia.out_val[2*DW +: DW]), W'(sv[2*DW +: DW]));
    chk("force_ch1_a", W'(ia.out_val[1*DW +: DW]), W'(cv[1*DW +: DW]));
    chk("force_rel_a", W'(ia.released), W'(4'b1111));
    chk("force_state_a", W'(ia.state), W'(3));
    force_hold = 4'b0000;
    rand_vals();
    do_step(TW'(TH + 401), 1'b0);
    chk("unforce_ch2_a", W'(ia.out_val[2*DW +: DW]), W'(cv[2*DW +: DW]));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/init_hold_switch_mc.md
Name: init_hold_switch_mc

Overview:
- Multi-channel, parametrised initial-value hold/release switch for the real-time simulation datapath (turbine / water-way models).
- During start-up it forwards the per-channel start values. Past a programmable sim-time threshold it releases channels one by one, in staggered order, onto the computed values.
- It re-arms on an explicit restart or when sim_time rolls back to a new run. One output update per simulation step strobe.

Parameters:
- DATA_W, 36, width of one channel value (extended-single word).
- N_CH, 4, number of channels.
- TIME_W, 32, sim_time width.
- T_HOLD, 10000, channels hold start value while sim_time <= T_HOLD.
- T_STAGGER, 16, simulation steps between successive channel releases; 0 = release all channels together.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- step_valid  in  1  one-cycle strobe per simulation step; sim_time, start_val and calc_val are valid with it.
- sim_time  in  TIME_W  current simulation time.
- start_val  in  N_CH*DATA_W  per-channel start values; channel i occupies [i*DATA_W +: DATA_W].
- calc_val  in  N_CH*DATA_W  per-channel computed values, same packing.
- restart  in  1  synchronous re-arm request.
- out_val  out  N_CH*DATA_W  registered selected values.
- out_valid  out  1  one-cycle pulse, asserted the cycle after step_valid.
- released  out  N_CH  per-channel flag; 1 = channel is forwarding calc_val.
- state  out  2  0 IDLE, 1 HOLD, 2 RELEASE, 3 RUN.

Behaviour:
- Reset (rst_n low, asynchronous): out_val=0, out_valid=0, released=0, state=IDLE, stagger counter=0, last_time=0.
- Only step_valid cycles advance the FSM. Outputs update on the clock edge sampling step_valid, so latency is 1 cycle. out_valid pulses for that 1 cycle only.
- Channel i output: calc_val[i] if released[i] after this step's update, else start_val[i]. The release decision and the output selection are made in the same step.
- IDLE: first step_valid -> HOLD, then evaluated as HOLD in that same step.
- HOLD: if sim_time > T_HOLD, set released[0] and reset the stagger counter.
  - T_STAGGER=0 or N_CH=1: release all channels -> RUN.
  - Otherwise -> RELEASE.
- RELEASE: count steps. When the counter reaches T_STAGGER, release the next channel (in ascending index order) and clear the counter. When channel N_CH-1 is released -> RUN.
- RUN: all released bits = 1; forward calc_val.
- Re-arm: triggers when restart=1 on any cycle, or when step_valid with sim_time < last_time (new run detected).
  - Effect: released=0, counter=0, state=HOLD.
  - Re-arm detected on a step_valid cycle: that step outputs start_val for all channels.
  - restart has priority over a same-cycle release.
- last_time updates on every step_valid.
- sim_time == T_HOLD counts as hold, since release requires strictly greater.
- Reset mid-release clears everything immediately; the next step_valid re-enters via IDLE.
- No arithmetic on data; values are passed through unmodified.

Optional Feature:
- Macro INIT_HOLD_FORCE_EN.
- Defined:
  - Adds input port force_hold [N_CH] and a per-channel mask.
  - A channel with force_hold=1 outputs start_val regardless of its released bit.
  - Its released bit still follows the FSM, so clearing force_hold resumes calc_val on the next step.
  - The state output is unaffected.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset then steps at sim_time=0..10000, start_val=0x111 per channel, calc_val=0x222 -> out_val all 0x111, state HOLD, released=0000, out_valid 1 cycle after each strobe.
- sim_time 10001, T_STAGGER=16, N_CH=4 -> released=0001 at step 10001, then 0011 at 16 steps later, 0111 at 32, 1111 at 48 (state RUN). Channel i switches to 0x222 on its release step.
- T_STAGGER=0 -> at sim_time 10001 released=1111, state RUN directly.
- In RUN, step with sim_time=5 after last_time=20000 -> released=0000, state HOLD, out_val=start_val on that step.
- restart asserted in the same cycle as the step that would release channel 2 -> restart wins: released=0000, state HOLD.
- rst_n pulled low mid-RELEASE, between clock edges -> outputs zero immediately (asynchronous).
- With INIT_HOLD_FORCE_EN, force_hold=0100 in RUN -> channel 2 = start_val, others calc_val; clear force_hold -> channel 2 = calc_val on the next step.
